// File: rtl/block_ram_fifo.sv
// -----------------------------------------------------------------------------
// block_ram_fifo
//   First-word-fall-through FIFO built on one 1R1W block RAM with a 1-cycle
//   registered read. The write side pushes straight into RAM. The read side
//   prefetches RAM words into a 2-slot output stage, which hides the RAM read
//   latency and sustains one word per cycle.
//
//   Optional feature macro: BLOCK_RAM_FIFO_FLUSH_EN adds the synchronous
//   'flush' input. Without the macro the FIFO is cleared only by rstN.
//
// Ports
//   clk     in   1               clock, all flops on posedge
//   rstN    in   1               asynchronous active-low reset
//   wValid  in   1               producer has wData
//   wReady  out  1               FIFO accepts wData this cycle
//   wData   in   ENTRY_BIT_SIZE  push data
//   rValid  out  1               rData holds the head word
//   rReady  in   1               consumer takes the head this cycle
//   rData   out  ENTRY_BIT_SIZE  head word, stable while rValid && !rReady
//   count   out  CW              words held (RAM + in-flight + stage)
//   flush   in   1               only with BLOCK_RAM_FIFO_FLUSH_EN
// -----------------------------------------------------------------------------
module block_ram_fifo #(
   parameter int ENTRY_NUM      = 1024,
   parameter int ENTRY_BIT_SIZE = 32
) (
   input  logic                                 clk,
   input  logic                                 rstN,
   input  logic                                 wValid,
   output logic                                 wReady,
   input  logic [ENTRY_BIT_SIZE-1:0]            wData,
   output logic                                 rValid,
   input  logic                                 rReady,
   output logic [ENTRY_BIT_SIZE-1:0]            rData,
   output logic [$clog2(ENTRY_NUM+3)-1:0]       count
`ifdef BLOCK_RAM_FIFO_FLUSH_EN
   ,
   input  logic                                 flush
`endif
);

   localparam int AW = $clog2(ENTRY_NUM);
   localparam int CW = $clog2(ENTRY_NUM+3);

   // RAM array and its registered read port
   logic [ENTRY_BIT_SIZE-1:0] r_mem [ENTRY_NUM];
   logic [ENTRY_BIT_SIZE-1:0] r_ramQ;

   // Control state
   logic [AW-1:0]             r_wrPtr;
   logic [AW-1:0]             r_rdPtr;
   logic [AW:0]               r_ramCnt;
   logic                      r_inFlight;
   logic [ENTRY_BIT_SIZE-1:0] r_stage0;
   logic [ENTRY_BIT_SIZE-1:0] r_stage1;
   logic [1:0]                r_stageCnt;
   logic [CW-1:0]             r_count;

   // Next-state / control wires
   logic                      w_push;
   logic                      w_pop;
   logic                      w_issue;
   logic                      w_memWe;
   logic [2:0]                w_pend;
   logic [AW-1:0]             w_wrPtrNxt;
   logic [AW-1:0]             w_rdPtrNxt;
   logic [AW:0]               w_ramCntNxt;
   logic                      w_inFlightNxt;
   logic [ENTRY_BIT_SIZE-1:0] w_stage0Nxt;
   logic [ENTRY_BIT_SIZE-1:0] w_stage1Nxt;
   logic [1:0]                w_stageCntNxt;
   logic [CW-1:0]             w_countNxt;

   // Full comes from the RAM occupancy only, so wReady never depends on rReady.
   assign wReady = (r_ramCnt != (AW+1)'(ENTRY_NUM));
   assign rValid = (r_stageCnt != 2'd0);
   assign rData  = r_stage0;
   assign count  = r_count;

   always_comb begin
      w_push        = wValid && wReady;
      w_pop         = rValid && rReady;
      // Words already committed to the stage (held or in flight) after this pop.
      // The stage plus the in-flight read never exceeds two words.
      w_pend        = {1'b0, r_stageCnt} + {2'b00, r_inFlight} - {2'b00, w_pop};
      w_issue       = (r_ramCnt != '0) && (w_pend < 3'd2);
      w_memWe       = w_push;

      w_wrPtrNxt    = r_wrPtr + AW'(w_push);
      w_rdPtrNxt    = r_rdPtr + AW'(w_issue);
      w_ramCntNxt   = r_ramCnt + (AW+1)'(w_push) - (AW+1)'(w_issue);
      w_inFlightNxt = w_issue;
      w_countNxt    = r_count + CW'(w_push) - CW'(w_pop);

      // Pop shifts slot 1 into the head, then a landing read fills the first free slot.
      w_stage0Nxt   = r_stage0;
      w_stage1Nxt   = r_stage1;
      w_stageCntNxt = r_stageCnt;
      if (w_pop) begin
         w_stage0Nxt   = r_stage1;
         w_stageCntNxt = r_stageCnt - 2'd1;
      end
      if (r_inFlight) begin
         if (w_stageCntNxt == 2'd0) begin
            w_stage0Nxt = r_ramQ;
         end else begin
            w_stage1Nxt = r_ramQ;
         end
         w_stageCntNxt = w_stageCntNxt + 2'd1;
      end

`ifdef BLOCK_RAM_FIFO_FLUSH_EN
      // Flush empties everything but leaves the head data word untouched.
      if (flush) begin
         w_memWe       = 1'b0;
         w_wrPtrNxt    = '0;
         w_rdPtrNxt    = '0;
         w_ramCntNxt   = '0;
         w_inFlightNxt = 1'b0;
         w_countNxt    = '0;
         w_stage0Nxt   = r_stage0;
         w_stage1Nxt   = r_stage1;
         w_stageCntNxt = 2'd0;
      end
`endif
   end

   // Block RAM: write and registered read, no reset on the array or read data.
   // The read address never equals the write address in the same cycle because
   // a read needs a non-empty RAM and a write needs a non-full RAM.
   always_ff @(posedge clk) begin
      if (w_memWe) begin
         r_mem[r_wrPtr] <= wData;
      end
      if (w_issue) begin
         r_ramQ <= r_mem[r_rdPtr];
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_ramCnt   <= '0;
         r_inFlight <= 1'b0;
         r_stage0   <= '0;
         r_stage1   <= '0;
         r_stageCnt <= 2'd0;
         r_count    <= '0;
      end else begin
         r_wrPtr    <= w_wrPtrNxt;
         r_rdPtr    <= w_rdPtrNxt;
         r_ramCnt   <= w_ramCntNxt;
         r_inFlight <= w_inFlightNxt;
         r_stage0   <= w_stage0Nxt;
         r_stage1   <= w_stage1Nxt;
         r_stageCnt <= w_stageCntNxt;
         r_count    <= w_countNxt;
      end
   end

endmodule
